// File: rtl/cache_array_2way.sv
// 2-way set-associative tag/data array with replacement state and invalidate sweep.
// Define CACHE_LRU_EN for per-set LRU; otherwise a global round-robin bit picks the victim.
module cache_way #(
  parameter int TAG_W    = 11,
  parameter int LINE_W   = 64,
  parameter int SET_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] idx,
  input  logic                wr,
  input  logic                wdirty,
  input  logic [TAG_W-1:0]    wtag,
  input  logic [LINE_W-1:0]   wdata,
  input  logic                clr,
  input  logic [SET_BITS-1:0] clr_idx,
  output logic                vld,
  output logic                drt,
  output logic [TAG_W-1:0]    tag,
  output logic [LINE_W-1:0]   data
);
  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]             vld_a, drt_a;
  logic [SETS-1:0][TAG_W-1:0]  tag_a;
  logic [SETS-1:0][LINE_W-1:0] data_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a  <= '0;
      drt_a  <= '0;
      tag_a  <= '0;
      data_a <= '0;
    end else begin
      if (wr) begin
        vld_a[idx]  <= 1'b1;
        drt_a[idx]  <= wdirty;
        tag_a[idx]  <= wtag;
        data_a[idx] <= wdata;
      end
      // wr requires ready, so it never coincides with a sweep clear
      if (clr) begin
        vld_a[clr_idx] <= 1'b0;
        drt_a[clr_idx] <= 1'b0;
      end
    end
  end

  assign vld  = vld_a[idx];
  assign drt  = drt_a[idx];
  assign tag  = tag_a[idx];
  assign data = data_a[idx];
endmodule

module cache_array_2way #(
  parameter int ADDR_W   = 14,
  parameter int LINE_W   = 64,
  parameter int SET_BITS = 3,
  parameter int TAG_W    = ADDR_W - SET_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wdirty,
  input  logic              flush,
  output logic [LINE_W-1:0] rd_data,
  output logic [TAG_W-1:0]  tag_out,
  output logic              hit,
  output logic              dirty,
  output logic              ready
);
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q, state_d;
  logic [SET_BITS-1:0]   cnt_q;
  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            w_vld, w_drt, w_wr, match;
  logic [1:0][TAG_W-1:0] w_tag;
  logic [1:0][LINE_W-1:0] w_data;
  logic                  any_hit, hit_way, victim, data_way, tag_way;
  logic                  do_wr, do_rd, sweeping;
  logic                  hit_q;

  assign set_idx  = addr[SET_BITS-1:0];
  assign req_tag  = addr[ADDR_W-1:SET_BITS];
  assign ready    = (state_q == IDLE);
  assign sweeping = (state_q == SWEEP);
  assign do_wr    = we & ready;
  assign do_rd    = re & ready & ~we;

  for (genvar g = 0; g < 2; g++) begin : g_way
    assign match[g] = w_vld[g] && (w_tag[g] == req_tag);
    assign w_wr[g]  = do_wr && (data_way == (g == 1));
    cache_way #(.TAG_W(TAG_W), .LINE_W(LINE_W), .SET_BITS(SET_BITS)) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .idx     (set_idx),
      .wr      (w_wr[g]),
      .wdirty  (wdirty),
      .wtag    (req_tag),
      .wdata   (wr_data),
      .clr     (sweeping),
      .clr_idx (cnt_q),
      .vld     (w_vld[g]),
      .drt     (w_drt[g]),
      .tag     (w_tag[g]),
      .data    (w_data[g])
    );
  end

  assign any_hit  = |match;
  assign hit_way  = match[1];
  assign data_way = any_hit ? hit_way : victim;

`ifdef CACHE_LRU_EN
  logic [(1<<SET_BITS)-1:0] lru_q;
  assign victim = lru_q[set_idx];
  // on a read hit, report the way that becomes the next victim
  assign tag_way = do_wr ? data_way : (any_hit ? ~hit_way : victim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lru_q <= '0;
    else if (sweeping) lru_q[cnt_q] <= 1'b0;
    else if (do_wr)    lru_q[set_idx] <= ~data_way;
    else if (do_rd && any_hit) lru_q[set_idx] <= ~hit_way;
  end
`else
  logic rr_q;
  assign victim  = rr_q;
  assign tag_way = do_wr ? data_way : victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rr_q <= 1'b0;
    else if (sweeping)          rr_q <= 1'b0;
    else if (do_wr && !any_hit) rr_q <= ~rr_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = SWEEP;
      SWEEP:   if (cnt_q == {SET_BITS{1'b1}}) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (sweeping) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      rd_data <= '0;
      tag_out <= '0;
      dirty   <= 1'b0;
    end else if (do_wr || do_rd) begin
      hit_q   <= any_hit;
      rd_data <= w_data[data_way];
      tag_out <= w_tag[tag_way];
      dirty   <= w_vld[tag_way] & w_drt[tag_way];
    end else if (sweeping) begin
      hit_q   <= 1'b0;
    end
  end

  // the flush-cycle request may have registered a hit; mask it while sweeping
  assign hit = hit_q & ready;
endmodule

// File: tb/tb_cache_array_2way.sv
// Table-driven bench with an expectation queue for cache_array_2way.
module tb_cache_array_2way;
  logic        clk, rst_n;
  logic [13:0] addr;
  logic        re, we, wdirty, flush;
  logic [63:0] wr_data, rd_data;
  logic [10:0] tag_out;
  logic        hit, dirty, ready;

  cache_array_2way dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wr_data(wr_data), .wdirty(wdirty), .flush(flush),
    .rd_data(rd_data), .tag_out(tag_out), .hit(hit), .dirty(dirty), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re, we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic        wdirty;
    logic [3:0]  mask;   // hit, data, tag, dirty
    logic        h;
    logic [63:0] d;
    logic [10:0] t;
    logic        dy;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  mask;
    logic        h;
    logic [63:0] d;
    logic [10:0] t;
    logic        dy;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [13:0] a,
                              input logic [63:0] wd, input logic wdy, input logic [3:0] m,
                              input logic h, input logic [63:0] d, input logic [10:0] t,
                              input logic dy);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.wdata = wd; v.wdirty = wdy;
    v.mask = m; v.h = h; v.d = d; v.t = t; v.dy = dy;
    return v;
  endfunction

  task automatic step(input string nm, input vec_t v, input logic fl);
    exp_t e;
    @(negedge clk);
    re = v.re; we = v.we; addr = v.addr; wr_data = v.wdata; wdirty = v.wdirty; flush = fl;
    e.nm = nm; e.mask = v.mask; e.h = v.h; e.d = v.d; e.t = v.t; e.dy = v.dy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.mask[3]) chk({e.nm, ".hit"},   64'(hit),     64'(e.h));
    if (e.mask[2]) chk({e.nm, ".data"},  rd_data,      e.d);
    if (e.mask[1]) chk({e.nm, ".tag"},   64'(tag_out), 64'(e.t));
    if (e.mask[0]) chk({e.nm, ".dirty"}, 64'(dirty),   64'(e.dy));
    if (!fl) chk({e.nm, ".ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int n;
    re = 0; we = 0; addr = '0; wr_data = '0; wdirty = 0; flush = 0; rst_n = 0;

    vt[0]  = mk(1, 0, 14'h0005, 0, 0, 4'b1001, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 14'h0011, 64'hA5A5_0000_0000_0001, 1, 4'b1001, 0, 0, 0, 0);
    vt[2]  = mk(1, 0, 14'h0011, 0, 0, 4'b1100, 1, 64'hA5A5_0000_0000_0001, 0, 0);
    vt[3]  = mk(0, 1, 14'h0019, 64'h3333, 1, 4'b1001, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 14'h0011, 0, 0, 4'b1100, 1, 64'hA5A5_0000_0000_0001, 0, 0);
`ifdef CACHE_LRU_EN
    vt[5]  = mk(0, 1, 14'h0021, 64'h4444, 0, 4'b1111, 0, 64'h3333, 11'h003, 1);
    vt[10] = mk(1, 0, 14'h0019, 0, 0, 4'b1111, 0, 64'hA5A5_0000_0000_0001, 11'h002, 1);
`else
    vt[5]  = mk(0, 1, 14'h0021, 64'h4444, 0, 4'b1111, 0, 64'hA5A5_0000_0000_0001, 11'h002, 1);
    vt[10] = mk(1, 0, 14'h0019, 0, 0, 4'b1100, 1, 64'h3333, 0, 0);
`endif
    vt[6]  = mk(1, 0, 14'h0021, 0, 0, 4'b1100, 1, 64'h4444, 0, 0);
    vt[7]  = mk(1, 1, 14'h0021, 64'h5555, 0, 4'b1111, 1, 64'h4444, 11'h004, 0);
    vt[8]  = mk(1, 0, 14'h0021, 0, 0, 4'b1100, 1, 64'h5555, 0, 0);
    vt[9]  = mk(0, 0, 14'h0021, 0, 0, 4'b1100, 1, 64'h5555, 0, 0);

    #12;
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.hit",   64'(hit),   64'd0);
    chk("rst.data",  rd_data,    64'd0);
    rst_n = 1;

    for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), vt[i], 1'b0);

    // fill all sets, flush with a hitting lookup in the same cycle
    for (int s = 0; s < 8; s++)
      step($sformatf("fill%0d", s), mk(0, 1, {11'h010, 3'(s)}, 64'h100 + 64'(s), 1'(s),
           4'b1000, 0, 0, 0, 0), 1'b0);
    step("flush_req", mk(1, 0, {11'h010, 3'd2}, 0, 0, 4'b1100, 0, 64'h102, 0, 0), 1'b1);
    @(negedge clk); flush = 0; re = 0; we = 0;
    n = 1;
    while (!ready && n < 20) begin
      chk("sweep.hit", 64'(hit), 64'd0);
      @(posedge clk); #1;
      if (!ready) n++;
    end
    chk("sweep.len", 64'(n), 64'd8);
    for (int s = 0; s < 8; s++)
      step($sformatf("post%0d", s), mk(1, 0, {11'h010, 3'(s)}, 0, 0, 4'b1000, 0, 0, 0, 0), 1'b0);

    // reset in the third sweep cycle
    step("pre_w0", mk(0, 1, {11'h030, 3'd4}, 64'hDEAD, 1, 4'b1000, 0, 0, 0, 0), 1'b0);
    step("pre_w1", mk(0, 1, {11'h010, 3'd7}, 64'h77, 1, 4'b1000, 0, 0, 0, 0), 1'b0);
    step("pre_rd", mk(1, 0, {11'h030, 3'd4}, 0, 0, 4'b1100, 1, 64'hDEAD, 0, 0), 1'b0);
    @(negedge clk); re = 0; flush = 1;
    @(negedge clk); flush = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 0;
    #1;
    chk("mid.ready", 64'(ready),   64'd1);
    chk("mid.hit",   64'(hit),     64'd0);
    chk("mid.data",  rd_data,      64'd0);
    chk("mid.tag",   64'(tag_out), 64'd0);
    chk("mid.dirty", 64'(dirty),   64'd0);
    @(negedge clk); rst_n = 1;
    step("after0", mk(1, 0, {11'h010, 3'd7}, 0, 0, 4'b1001, 0, 0, 0, 0), 1'b0);
    step("after1", mk(1, 0, {11'h030, 3'd4}, 0, 0, 4'b1001, 0, 0, 0, 0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_array_2way.md
# cache_array_2way

Parametrised 2-way set-associative cache tag/data array with valid, dirty and per-set replacement state, and a sequential invalidate sweep. It is the successor to the direct-mapped array in the pipelined CPU's memory path, for both I-side and D-side. Read lookups and writes are clocked. Victim tag and dirty status are presented for the cache controller's eviction logic. Hit/miss handling, write-back and memory handshakes remain in the controller.

## Interface
- ADDR_W, 14: word address width; the two byte-offset LSBs are already dropped.
- LINE_W, 64: cache line width in bits.
- SET_BITS, 3: log2 of set count, giving 2^SET_BITS sets; tag width TAG_W = ADDR_W - SET_BITS.

- clk  in  1  system clock; all state changes occur on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all valid, dirty and replacement bits plus output registers.
- addr  in  ADDR_W  lookup/write address; set = addr[SET_BITS-1:0], tag = addr[ADDR_W-1:SET_BITS].
- re  in  1  lookup request.
- we  in  1  line write request.
- wr_data  in  LINE_W  line to write.
- wdirty  in  1  dirty bit written with the line.
- flush  in  1  single-cycle pulse that starts the invalidate sweep.
- rd_data  out  LINE_W  hit-way line on hit; victim-way line on miss.
- tag_out  out  TAG_W  victim-way tag, used for eviction.
- hit  out  1  registered tag match on a valid way.
- dirty  out  1  victim way valid and dirty.
- ready  out  1  high when the array accepts re/we; low during the sweep.

## Operation
- Storage per set: two ways, each holding {valid, dirty, tag, data}, plus replacement state.
- Lookup (re=1, ready=1): compare the tag against both ways.
  - hit = 1 if exactly one valid way matches. A match on both ways cannot occur by construction.
  - On hit: rd_data = matching way's data. Replacement state marks the other way as victim.
  - On miss: rd_data, tag_out and dirty come from the victim way. Replacement state is unchanged.
- Write (we=1, ready=1):
  - If a valid way's tag matches, that way is overwritten. Otherwise the victim way is overwritten.
  - The written way becomes {1, wdirty, tag, wr_data}. The other way becomes victim.
  - hit output = 1 if the tag matched, else 0.
  - rd_data, tag_out and dirty show the pre-write contents of the written way.
- re and we in the same cycle: write has priority. Read-before-write: the outputs show the old contents.
- Output registers hold their values when re=0 and we=0.
- Flush:
  - flush sampled with ready=1 starts the sweep. Each cycle, one set has both valid bits, both dirty bits and its replacement state cleared, in order set 0 to 2^SET_BITS-1.
  - Dirty data is discarded. The controller must write back dirty lines before issuing flush.
  - During the sweep, re, we and flush are ignored and hit is forced to 0.
- Sweep FSM:
  - IDLE -> SWEEP on flush.
  - SWEEP -> IDLE after the set counter reaches the last set; the counter wraps to 0.

## Timing
- Lookup/write latency: 1 cycle. The request is sampled at edge N; outputs are valid after edge N; array updates are visible to a lookup sampled at edge N+1.
- Flush sampled at edge N: ready = 0 after edge N. Sets 0..S-1 (S = 2^SET_BITS) are cleared at edges N+1..N+S. ready = 1 after edge N+S.
- A request sampled in the same cycle as flush is executed before the sweep. Its write is then invalidated.
- Reset value of every output is 0, except ready = 1. Sweep state returns to IDLE.
- Reset asserted mid-sweep aborts the sweep. All state is cleared immediately.

## Configuration
- CACHE_LRU_EN defined: one LRU bit per set, updated as described in Operation.
- CACHE_LRU_EN undefined:
  - The victim is chosen by a single global round-robin bit. It toggles on every write that misses.
  - Hits do not change replacement state.
  - Per-set LRU bits are not built.

## Test plan
- Reset, then re with addr=0x0005 -> hit=0, dirty=0, ready=1.
- we addr=0x0011, wr_data=0xA5A5_0000_0000_0001, wdirty=1; then re addr=0x0011 -> hit=1, rd_data=0xA5A5_0000_0000_0001.
- Fill set 1 with tags 0x002 and 0x003, reading tag 0x002 last; then we tag 0x004 -> with CACHE_LRU_EN, tag 0x003 is evicted (tag_out=0x003, dirty=1 if written dirty).
- Same addr with re and we together -> outputs show old line; re next cycle shows new line.
- flush after filling all 8 sets -> ready low for exactly 8 cycles; every subsequent lookup gives hit=0.
- Assert rst_n low on the 3rd sweep cycle -> ready=1 and all outputs 0 immediately; lookups miss after release.
